riscv_mem_arb: RTL and testbench
================================

// Module: riscv_mem_arb
// PURPOSE
//  Arbitrates one shared memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
//  The LSU drives mem_read/mem_write as decoded from LOAD/STORE opcodes.
//  Allows one outstanding transaction at a time, with fixed LSU priority and an IFU anti-starvation override.
//  Sits between the core's fetch/LSU stages and the single-ported memory/bus bridge.
//  Registers all responses back to the requesters. A watchdog returns an error response when the memory never responds.
// PARAMETERS
//  AW            64   address width
//  DW            64   data width; mask width is DW/8
//  TIMEOUT_CYC   255  cycles in REQ+WAIT before error response; 0 disables the watchdog
//  STARVE_LIMIT  4    consecutive LSU grants with ifu_req pending before IFU is forced to win once
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  ifu_req     in   1       fetch request; hold with ifu_addr until ifu_gnt
//  ifu_addr    in   AW      fetch address
//  ifu_gnt     out  1       request accepted this cycle (combinational, IDLE only)
//  ifu_rvalid  out  1       one-cycle response pulse
//  ifu_rdata   out  DW      fetch data; valid with ifu_rvalid
//  ifu_err     out  1       timeout error; valid with ifu_rvalid
//  lsu_req     in   1       load/store request; hold with payload until lsu_gnt
//  lsu_we      in   1       1=store (mem_write), 0=load (mem_read)
//  lsu_addr    in   AW      data address
//  lsu_wdata   in   DW      store data
//  lsu_wmask   in   DW/8    byte write strobes
//  lsu_gnt     out  1       request accepted this cycle
//  lsu_rvalid  out  1       one-cycle response pulse; for stores this is the write acknowledge
//  lsu_rdata   out  DW      load data; 0 for stores
//  lsu_err     out  1       timeout error; valid with lsu_rvalid
//  mem_req     out  1       memory request; held until mem_gnt
//  mem_we      out  1       memory write enable
//  mem_addr    out  AW      latched address
//  mem_wdata   out  DW      latched write data
//  mem_wmask   out  DW/8    latched strobes; all-zero for reads
//  mem_gnt     in   1       memory accepted mem_req
//  mem_rvalid  in   1       memory response (read data or write ack)
//  mem_rdata   in   DW      memory read data
// BEHAVIOUR
//  Reset (async, any state):
//   - state <= IDLE; owner, starve_cnt and wd_cnt <= 0.
//   - All outputs 0, including the mem_* payload.
//   - A memory response in flight at reset is discarded.
//  IDLE:
//   - If lsu_req and starve_cnt<STARVE_LIMIT, grant LSU. Otherwise, if ifu_req, grant IFU.
//   - If the limit is reached and ifu_req is low, LSU wins.
//   - Exactly one x_gnt is high, combinationally, in the cycle of selection.
//   - On that edge: latch payload into mem_*, record owner, wd_cnt<=0, go to REQ.
//   - IFU requests drive mem_we=0 and mem_wmask=0.
//  starve_cnt update (only when a grant occurs):
//   - +1 on an LSU grant while ifu_req is high.
//   - Cleared on any IFU grant.
//   - Cleared on an LSU grant with ifu_req low.
//   - Saturates at STARVE_LIMIT.
//  REQ:
//   - mem_req=1; payload stable.
//   - mem_gnt & ~mem_rvalid -> WAIT, and mem_req drops the next cycle.
//   - mem_gnt & mem_rvalid (zero-latency memory) -> complete, as in WAIT.
//  WAIT:
//   - mem_rvalid -> next cycle owner's x_rvalid=1, x_rdata=mem_rdata (0 if store), x_err=0; state -> IDLE.
//  Watchdog:
//   - wd_cnt increments every cycle in REQ/WAIT.
//   - When wd_cnt==TIMEOUT_CYC-1 with no completion, the next cycle gives owner x_rvalid=1, x_err=1, x_rdata=0.
//   - mem_req drops; state -> IDLE.
//   - A completion in that same cycle takes precedence (normal response).
//  Stray responses:
//   - mem_rvalid in IDLE, or arriving after a timeout, is ignored.
//   - There is no tag; the memory must not return a late response for a timed-out request.
//  Non-owner outputs: x_rvalid, x_rdata and x_err of the non-owner stay 0.
//   - x_rvalid is a single-cycle pulse.
//   - x_rdata/x_err hold until the next response.
//  Latency:
//   - gnt at cycle N, mem_req at N+1; with mem_gnt and mem_rvalid both at N+1, x_rvalid at N+2.
//   - Back-to-back: the next x_gnt can occur in the same cycle as x_rvalid.
//  Requests asserted while not IDLE wait; no gnt is given and there is no queueing.
// TESTING
//  - Reset mid-WAIT (rst_n low 1 cycle) -> all outputs 0; a mem_rvalid 2 cycles later produces no x_rvalid.
//  - Single IFU fetch addr=0x8000_0000, mem_gnt=1 at N+1, mem_rvalid 3 cycles later with rdata=0x13 -> ifu_rvalid=1, ifu_rdata=0x13, ifu_err=0.
//  - ifu_req and lsu_req (store, addr=0x100, wmask=0x0F) in the same cycle -> lsu_gnt first; mem_we=1, mem_wmask=0x0F; IFU is granted in the cycle of lsu_rvalid.
//  - ifu_req held high with 5 back-to-back LSU loads, STARVE_LIMIT=4 -> grant order L,L,L,L,I,L.
//  - TIMEOUT_CYC=8, mem_gnt never asserted -> lsu_rvalid=1, lsu_err=1, lsu_rdata=0 exactly 9 cycles after lsu_gnt; then back in IDLE.
//  - Zero-latency memory (mem_gnt and mem_rvalid tied to mem_req, rdata=0xDEAD) -> lsu_rvalid 2 cycles after gnt; sustained throughput of one grant every 2 cycles.

Source files
------------

// File: rtl/riscv_mem_arb_if.sv
// Request/response bundle between the IFU, the LSU, the arbiter and the shared memory port.
// slave = arbiter view, master = view of the requesters and memory around it.
interface riscv_mem_arb_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic              ifu_req;
    logic [AW-1:0]     ifu_addr;
    logic              ifu_gnt;
    logic              ifu_rvalid;
    logic [DW-1:0]     ifu_rdata;
    logic              ifu_err;

    logic              lsu_req;
    logic              lsu_we;
    logic [AW-1:0]     lsu_addr;
    logic [DW-1:0]     lsu_wdata;
    logic [DW/8-1:0]   lsu_wmask;
    logic              lsu_gnt;
    logic              lsu_rvalid;
    logic [DW-1:0]     lsu_rdata;
    logic              lsu_err;

    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wmask;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  ifu_req, ifu_addr,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
        output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req, ifu_addr,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
        input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/riscv_mem_arb.sv
// IFU/LSU arbiter for one memory port: LSU priority, IFU anti-starvation, watchdog error response.
// Latency: gnt at N, mem_req at N+1, response one cycle after memory completion.
// Backpressure: one transaction in flight; requests outside IDLE are held off (no gnt).
module riscv_mem_arb #(
    parameter int AW           = 64,
    parameter int DW           = 64,
    parameter int TIMEOUT_CYC  = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    riscv_mem_arb_if.slave bus
);
    localparam int MW  = DW / 8;
    localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYC != 0);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [SCW-1:0] SC_MAX  = SCW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state;
    logic            owner_lsu;
    logic [SCW-1:0]  starve_cnt;
    logic [WDW-1:0]  wd_cnt;

    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [MW-1:0]   mem_wmask_q;

    logic            ifu_rvalid_q, ifu_err_q;
    logic [DW-1:0]   ifu_rdata_q;
    logic            lsu_rvalid_q, lsu_err_q;
    logic [DW-1:0]   lsu_rdata_q;

    logic            busy, lsu_win, ifu_win, done_ok, wd_expire, rsp_fire;
    logic [DW-1:0]   rsp_dat;
    logic [SCW-1:0]  starve_inc;

    always_comb begin
        busy       = (state == REQ) || (state == WAIT);
        // LSU loses only when the starvation budget is spent and the IFU is actually waiting
        lsu_win    = (state == IDLE) && bus.lsu_req &&
                     ((starve_cnt < SC_MAX) || !bus.ifu_req);
        ifu_win    = (state == IDLE) && bus.ifu_req && !lsu_win;
        done_ok    = ((state == REQ) && bus.mem_gnt && bus.mem_rvalid) ||
                     ((state == WAIT) && bus.mem_rvalid);
        wd_expire  = WD_EN && busy && (wd_cnt == WD_LAST) && !done_ok;
        rsp_fire   = done_ok || wd_expire;
        rsp_dat    = (done_ok && !mem_we_q) ? bus.mem_rdata : '0;
        starve_inc = (starve_cnt == SC_MAX) ? SC_MAX : starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner_lsu    <= 1'b0;
            starve_cnt   <= '0;
            wd_cnt       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            ifu_rvalid_q <= 1'b0;
            ifu_rdata_q  <= '0;
            ifu_err_q    <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            lsu_rdata_q  <= '0;
            lsu_err_q    <= 1'b0;
        end else begin
            if (rsp_fire) begin
                lsu_rvalid_q <= owner_lsu;
                lsu_rdata_q  <= owner_lsu ? rsp_dat : '0;
                lsu_err_q    <= owner_lsu && wd_expire;
                ifu_rvalid_q <= !owner_lsu;
                ifu_rdata_q  <= owner_lsu ? '0 : rsp_dat;
                ifu_err_q    <= !owner_lsu && wd_expire;
            end else begin
                lsu_rvalid_q <= 1'b0;
                ifu_rvalid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (lsu_win || ifu_win) begin
                        state       <= REQ;
                        mem_req_q   <= 1'b1;
                        wd_cnt      <= '0;
                        owner_lsu   <= lsu_win;
                        mem_we_q    <= lsu_win && bus.lsu_we;
                        mem_addr_q  <= lsu_win ? bus.lsu_addr : bus.ifu_addr;
                        mem_wdata_q <= lsu_win ? bus.lsu_wdata : '0;
                        mem_wmask_q <= (lsu_win && bus.lsu_we) ? bus.lsu_wmask : '0;
                        starve_cnt  <= (lsu_win && bus.ifu_req) ? starve_inc : '0;
                    end
                end
                REQ, WAIT: begin
                    if (rsp_fire) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                    end else begin
                        if ((state == REQ) && bus.mem_gnt) begin
                            state     <= WAIT;
                            mem_req_q <= 1'b0;
                        end
                        if (WD_EN) wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ifu_gnt    = ifu_win;
    assign bus.lsu_gnt    = lsu_win;
    assign bus.ifu_rvalid = ifu_rvalid_q;
    assign bus.ifu_rdata  = ifu_rdata_q;
    assign bus.ifu_err    = ifu_err_q;
    assign bus.lsu_rvalid = lsu_rvalid_q;
    assign bus.lsu_rdata  = lsu_rdata_q;
    assign bus.lsu_err    = lsu_err_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wmask  = mem_wmask_q;
endmodule

// File: tb/tb_riscv_mem_arb.sv
// Directed bench for riscv_mem_arb with a transaction-level reference model checked every cycle.
module tb_riscv_mem_arb;
    localparam int TO  = 8;
    localparam int SLIM = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic        zl, mg, mrv;
    logic [63:0] mrd;

    riscv_mem_arb_if #(.AW(64), .DW(64)) bus ();

    riscv_mem_arb #(.AW(64), .DW(64), .TIMEOUT_CYC(TO), .STARVE_LIMIT(SLIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // zero-latency memory: accept and answer in the same cycle as mem_req
    assign bus.mem_gnt    = zl ? bus.mem_req : mg;
    assign bus.mem_rvalid = zl ? bus.mem_req : mrv;
    assign bus.mem_rdata  = zl ? 64'hDEAD : mrd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_busy, m_acc, m_lsu, m_we;
    int          m_age, m_starve;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_wmask;
    bit          e_irv, e_ier, e_lrv, e_ler;
    logic [63:0] e_ird, e_lrd;

    always @(negedge clk) begin
        bit lw, iw, fin;
        logic [63:0] d;
        if (!rst_n) begin
            m_busy = 0; m_acc = 0; m_lsu = 0; m_we = 0; m_age = 0; m_starve = 0;
            m_addr = '0; m_wdata = '0; m_wmask = '0;
            e_irv = 0; e_ier = 0; e_ird = '0; e_lrv = 0; e_ler = 0; e_lrd = '0;
            chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_mem_wdata", bus.mem_wdata, 0);
            chk("rst_mem_wmask", bus.mem_wmask, 0);
        end
        lw = rst_n && !m_busy && bus.lsu_req && (m_starve < SLIM || !bus.ifu_req);
        iw = rst_n && !m_busy && bus.ifu_req && !lw;
        chk("lsu_gnt", bus.lsu_gnt, lw);
        chk("ifu_gnt", bus.ifu_gnt, iw);
        chk("mem_req", bus.mem_req, m_busy && !m_acc);
        if (m_busy && !m_acc) begin
            chk("mem_we", bus.mem_we, m_we);
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_wmask", bus.mem_wmask, m_wmask);
            if (m_lsu) chk("mem_wdata", bus.mem_wdata, m_wdata);
        end
        chk("ifu_rvalid", bus.ifu_rvalid, e_irv);
        chk("ifu_rdata", bus.ifu_rdata, e_ird);
        chk("ifu_err", bus.ifu_err, e_ier);
        chk("lsu_rvalid", bus.lsu_rvalid, e_lrv);
        chk("lsu_rdata", bus.lsu_rdata, e_lrd);
        chk("lsu_err", bus.lsu_err, e_ler);

        if (rst_n) begin
            e_irv = 0; e_lrv = 0;
            if (m_busy) begin
                fin = m_acc ? bus.mem_rvalid : (bus.mem_gnt && bus.mem_rvalid);
                if (fin || m_age == TO - 1) begin
                    d = (fin && !m_we) ? bus.mem_rdata : 64'h0;
                    if (m_lsu) begin
                        e_lrv = 1; e_lrd = d; e_ler = !fin; e_ird = '0; e_ier = 0;
                    end else begin
                        e_irv = 1; e_ird = d; e_ier = !fin; e_lrd = '0; e_ler = 0;
                    end
                    m_busy = 0;
                end else begin
                    if (!m_acc && bus.mem_gnt) m_acc = 1;
                    m_age++;
                end
            end else if (lw || iw) begin
                m_busy = 1; m_acc = 0; m_age = 0; m_lsu = lw;
                m_we    = lw && bus.lsu_we;
                m_addr  = lw ? bus.lsu_addr : bus.ifu_addr;
                m_wdata = bus.lsu_wdata;
                m_wmask = (lw && bus.lsu_we) ? bus.lsu_wmask : 8'h00;
                m_starve = (lw && bus.ifu_req) ? ((m_starve + 1 > SLIM) ? SLIM : m_starve + 1) : 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic get_gnt(input bit lsu, output int c);
        c = -1;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (lsu ? bus.lsu_gnt : bus.ifu_gnt) begin
                c = cyc;
                break;
            end
            nxt();
        end
        chk(lsu ? "lsu_gnt_seen" : "ifu_gnt_seen", (c >= 0), 1);
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int    n, lcnt, last_l;
        bit    idone;
        string got_s;
        int    gcyc[$];

        rst_n = 1'b0; zl = 1'b0; mg = 1'b0; mrv = 1'b0; mrd = '0;
        bus.ifu_req = 0; bus.ifu_addr = '0;
        bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_addr = '0; bus.lsu_wdata = '0; bus.lsu_wmask = '0;

        smp();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_ifu_rvalid", bus.ifu_rvalid, 0);
        chk("rst_lsu_rvalid", bus.lsu_rvalid, 0);
        nxt();
        rst_n = 1'b1;

        // single IFU fetch, mem_gnt at N+1, mem_rvalid 3 cycles later
        nxt();
        bus.ifu_req = 1; bus.ifu_addr = 64'h8000_0000;
        get_gnt(0, n);
        nxt(); bus.ifu_req = 0; mg = 1;
        nxt(); mg = 0;
        nxt();
        nxt(); mrv = 1; mrd = 64'h13;
        nxt(); mrv = 0;
        smp();
        chk("fetch_rvalid", bus.ifu_rvalid, 1);
        chk("fetch_rdata", bus.ifu_rdata, 64'h13);
        chk("fetch_err", bus.ifu_err, 0);
        chk("fetch_latency", cyc - n, 5);

        // simultaneous requests: LSU store first, IFU granted alongside lsu_rvalid
        nxt();
        bus.ifu_req = 1; bus.ifu_addr = 64'h8000_0004;
        bus.lsu_req = 1; bus.lsu_we = 1; bus.lsu_addr = 64'h100;
        bus.lsu_wdata = 64'h1122_3344; bus.lsu_wmask = 8'h0F;
        smp();
        chk("both_lsu_first", bus.lsu_gnt, 1);
        chk("both_ifu_waits", bus.ifu_gnt, 0);
        nxt(); bus.lsu_req = 0; mg = 1;
        smp();
        chk("store_mem_we", bus.mem_we, 1);
        chk("store_mem_wmask", bus.mem_wmask, 8'h0F);
        chk("store_mem_addr", bus.mem_addr, 64'h100);
        nxt(); mg = 0; mrv = 1; mrd = 64'hBAD;
        nxt(); mrv = 0;
        smp();
        chk("store_ack", bus.lsu_rvalid, 1);
        chk("store_rdata_zero", bus.lsu_rdata, 0);
        chk("ifu_gnt_on_ack", bus.ifu_gnt, 1);
        nxt(); bus.ifu_req = 0; mg = 1; mrv = 1; mrd = 64'h55;
        nxt(); mg = 0; mrv = 0;
        smp();
        chk("ifu2_rdata", bus.ifu_rdata, 64'h55);

        // starvation override with a zero-latency memory
        nxt();
        zl = 1;
        bus.ifu_req = 1; bus.ifu_addr = 64'h8000_0100;
        bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 64'h300; bus.lsu_wmask = 8'hFF;
        lcnt = 0; idone = 0; got_s = ""; last_l = -100;
        for (int k = 0; k < 40 && !(lcnt == 5 && idone); k++) begin
            smp();
            if (bus.lsu_rvalid) begin
                chk("zl_rdata", bus.lsu_rdata, 64'hDEAD);
                chk("zl_rsp_latency", cyc - last_l, 2);
            end
            if (bus.lsu_gnt) begin
                got_s = {got_s, "L"}; lcnt++; last_l = cyc; gcyc.push_back(cyc);
            end
            if (bus.ifu_gnt) begin
                got_s = {got_s, "I"}; idone = 1; gcyc.push_back(cyc);
            end
            nxt();
            if (idone) bus.ifu_req = 0;
            if (lcnt == 5) bus.lsu_req = 0;
        end
        chk("starve_complete", (lcnt == 5 && idone), 1);
        total++;
        if (got_s != "LLLLIL") begin
            bad++;
            $display("FAIL grant_order got=%s exp=LLLLIL", got_s);
        end
        for (int k = 1; k < gcyc.size(); k++) chk("zl_grant_spacing", gcyc[k] - gcyc[k-1], 2);
        nxt();
        zl = 0;

        // watchdog: memory never grants
        bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 64'h200;
        get_gnt(1, n);
        nxt(); bus.lsu_req = 0;
        repeat (7) nxt();
        smp();
        chk("to_not_early", bus.lsu_rvalid, 0);
        nxt();
        smp();
        chk("to_rvalid", bus.lsu_rvalid, 1);
        chk("to_err", bus.lsu_err, 1);
        chk("to_rdata", bus.lsu_rdata, 0);
        chk("to_latency", cyc - n, 9);
        nxt(); mrv = 1; mrd = 64'h77;
        nxt(); mrv = 0;
        smp();
        chk("stray_ignored", bus.lsu_rvalid, 0);

        // reset while waiting for the memory; the late response must vanish
        nxt();
        bus.lsu_req = 1; bus.lsu_addr = 64'h400;
        smp();
        chk("idle_after_timeout", bus.lsu_gnt, 1);
        nxt(); bus.lsu_req = 0; mg = 1;
        nxt(); mg = 0;
        nxt(); rst_n = 1'b0;
        smp();
        chk("midrst_mem_req", bus.mem_req, 0);
        chk("midrst_lsu_rdata", bus.lsu_rdata, 0);
        nxt(); rst_n = 1'b1;
        nxt(); mrv = 1; mrd = 64'h99;
        nxt(); mrv = 0;
        smp();
        chk("postrst_no_lsu_rvalid", bus.lsu_rvalid, 0);
        chk("postrst_no_ifu_rvalid", bus.ifu_rvalid, 0);
        nxt();
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
